// File: rtl/count_checker.sv
// Lock-and-check monitor for three counter buses that should increment together.
// Optional skew check across the buses is built when COUNT_CHECKER_SKEW_EN is defined.
module count_checker #(
    parameter int LOCK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] count_a,
    input  logic [7:0] count_b,
    input  logic [7:0] count_c,
    input  logic       err_clr,
    output logic       locked,
    output logic       fault,
    output logic [2:0] err_seq,
    output logic       err_skew,
    output logic [7:0] err_cnt,
    output logic       wrap
);

    localparam logic [1:0] ST_ACQ    = 2'd0;
    localparam logic [1:0] ST_TRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CYCLES);

    logic [1:0] state;
    logic [7:0] prev_a, prev_b, prev_c;
    logic [3:0] clean_cnt;
    logic [2:0] seq_hit;
    logic       skew_hit;
    logic       any_err;
    logic       chk_en;
    logic [7:0] err_cnt_inc;

    // Each bus must step by exactly one from its previous sample; 8'hFF->8'h00 falls out of mod-256 add.
    assign seq_hit = {count_c != prev_c + 8'd1,
                      count_b != prev_b + 8'd1,
                      count_a != prev_a + 8'd1};

`ifdef COUNT_CHECKER_SKEW_EN
    assign skew_hit = (count_a != count_b) || (count_a != count_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_skew <= 1'b0;
        else        err_skew <= chk_en && skew_hit;
    end
`else
    assign skew_hit = 1'b0;
    assign err_skew = 1'b0;
`endif

    assign any_err     = (|seq_hit) || skew_hit;
    assign chk_en      = (state == ST_LOCKED) || (state == ST_FAULT);
    assign locked      = chk_en;
    assign err_cnt_inc = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_ACQ;
            prev_a    <= 8'h00;
            prev_b    <= 8'h00;
            prev_c    <= 8'h00;
            clean_cnt <= 4'd0;
            fault     <= 1'b0;
            err_cnt   <= 8'h00;
            err_seq   <= 3'b000;
            wrap      <= 1'b0;
        end else begin
            prev_a  <= count_a;
            prev_b  <= count_b;
            prev_c  <= count_c;
            err_seq <= chk_en ? seq_hit : 3'b000;
            wrap    <= chk_en && (prev_a == 8'hFF) && (count_a == 8'h00);

            case (state)
                ST_ACQ: begin
                    clean_cnt <= 4'd0;
                    state     <= ST_TRAIN;
                end
                ST_TRAIN: begin
                    if (any_err) begin
                        clean_cnt <= 4'd0;
                    end else if (clean_cnt + 4'd1 == LOCK_N) begin
                        clean_cnt <= 4'd0;
                        state     <= ST_LOCKED;
                    end else begin
                        clean_cnt <= clean_cnt + 4'd1;
                    end
                end
                ST_LOCKED: begin
                    // A clear coinciding with an error still counts that error.
                    if (any_err) begin
                        state   <= ST_FAULT;
                        fault   <= 1'b1;
                        err_cnt <= err_clr ? 8'd1 : err_cnt_inc;
                    end else if (err_clr) begin
                        err_cnt <= 8'h00;
                    end
                end
                default: begin
                    // Clear wins over a same-cycle error and restarts acquisition.
                    if (err_clr) begin
                        state   <= ST_ACQ;
                        fault   <= 1'b0;
                        err_cnt <= 8'h00;
                    end else if (any_err) begin
                        err_cnt <= err_cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 4, meaning consecutive clean samples required before lock (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, meaning single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning reset, asynchronous, active-low.
REQ-004 SHALL have port count_a, input, 8, meaning first free-running counter bus under check.
REQ-005 SHALL have port count_b, input, 8, meaning second counter bus under check.
REQ-006 SHALL have port count_c, input, 8, meaning third counter bus under check.
REQ-007 SHALL have port err_clr, input, 1, meaning synchronous request to clear fault and error count.
REQ-008 SHALL have port locked, output, 1, meaning checker has locked to the counters and is reporting errors.
REQ-009 SHALL have port fault, output, 1, meaning sticky indication that an error was seen while locked.
REQ-010 SHALL have port err_seq, output, 3, meaning per-bus sequence error flags: bit0 a, bit1 b, bit2 c.
REQ-011 SHALL have port err_skew, output, 1, meaning the three buses disagreed on the same sample.
REQ-012 SHALL have port err_cnt, output, 8, meaning saturating count of error cycles.
REQ-013 SHALL have port wrap, output, 1, meaning one-cycle pulse when count_a wrapped from 8'hFF to 8'h00.

Function
REQ-014 SHALL register all three buses every clk edge into prev_a/b/c; checks compare the current input against prev.
REQ-015 SHALL flag a sequence error on a bus when its input != (prev + 1) mod 256; 8'hFF -> 8'h00 is legal.
REQ-016 SHALL flag a skew error when count_a, count_b, count_c are not all equal.
REQ-017 SHALL implement states ACQ, TRAIN, LOCKED, FAULT.
REQ-018 ACQ: SHALL capture prev and go to TRAIN on the next edge; no checks are made.
REQ-019 TRAIN: SHALL increment a clean-sample counter on each error-free sample and reset it to 0 on any error; SHALL go to LOCKED when it reaches LOCK_CYCLES; errors are not reported.
REQ-020 LOCKED: on any error SHALL go to FAULT, assert fault, and increment err_cnt.
REQ-021 FAULT: SHALL keep checking and increment err_cnt on each error cycle; on err_clr SHALL clear fault and err_cnt and go to ACQ.
REQ-022 err_clr in LOCKED SHALL clear err_cnt; if an error occurs in the same cycle, err_cnt SHALL become 1 and the state SHALL go to FAULT.
REQ-023 err_clr in FAULT together with an error SHALL give priority to clear: err_cnt=0, state=ACQ.
REQ-024 err_seq and err_skew SHALL be registered, valid one cycle after the offending sample's edge, and asserted only in LOCKED/FAULT.
REQ-025 err_cnt SHALL saturate at 8'hFF and SHALL NOT wrap.
REQ-026 locked SHALL be 1 in LOCKED and FAULT, and 0 in ACQ and TRAIN.
REQ-027 wrap SHALL pulse for exactly one cycle after the edge sampling prev_a=8'hFF and count_a=8'h00, only in LOCKED/FAULT.

Reset
REQ-028 reset low SHALL immediately force state ACQ, prev regs 0, clean counter 0, and all outputs 0, regardless of clk.
REQ-029 Reset asserted mid-operation (including in FAULT) SHALL discard all history; after release, lock SHALL take 1+LOCK_CYCLES clean samples.

Configuration
REQ-030 With macro COUNT_CHECKER_SKEW_EN defined, skew checking SHALL be built and SHALL contribute to errors per REQ-016/020/021.
REQ-031 Without COUNT_CHECKER_SKEW_EN, skew logic SHALL be absent, err_skew SHALL be tied 0, and only sequence errors SHALL count.

Verification
REQ-032 Release reset, drive three identical counters from 0 incrementing each cycle -> locked rises exactly 1+LOCK_CYCLES edges after release (5 with default); no error flags.
REQ-033 Locked, count_b jumps 8'h10 -> 8'h12 -> err_seq=3'b010 one cycle later; fault=1; err_cnt=1; with SKEW_EN, err_skew=1.
REQ-034 Locked counters pass 8'hFE, 8'hFF, 8'h00 -> wrap pulses one cycle, no errors.
REQ-035 In FAULT, inject 300 error cycles -> err_cnt stops at 8'hFF; assert err_clr -> err_cnt=0, fault=0, locked=0, relock after 5 clean samples.
REQ-036 Assert reset low between edges while in FAULT -> all outputs 0 immediately, before the next clk edge.
REQ-037 Build without COUNT_CHECKER_SKEW_EN; drive count_c offset +3 but incrementing -> no errors, locked=1, err_skew=0.
